// File: rtl/result_fmt.sv
// result_fmt: converts a signed N-bit result (or overflow flag) into an ASCII decimal string, one byte per handshake.
// Define RESULT_FMT_TERM_NUL_EN to append a NUL terminator byte after every string.
module result_fmt #(
  parameter int N      = 16,
  parameter int DIGITS = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_value,
  input  logic         in_overflow,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_char,
  output logic         out_last,
  output logic         busy
);
`ifdef RESULT_FMT_TERM_NUL_EN
  localparam logic TERM_NUL = 1'b1;
`else
  localparam logic TERM_NUL = 1'b0;
`endif
  localparam int CW = $clog2(DIGITS + 1);
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  typedef enum logic [2:0] {IDLE, CONV, SIGN, EMIT, ERR} state_t;

  state_t        state, state_n;
  logic [N-1:0]  work, work_n;
  logic [3:0]    rem, rem_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [CW-1:0] dcount, dcount_n;
  logic          neg, neg_n;
  logic [1:0]    err_idx, err_idx_n;
  logic          out_valid_n, out_last_n;
  logic [7:0]    out_char_n;
  logic          push, xfer;
  logic [3:0]    stack [DIGITS];
  logic [CW-1:0] top_idx, nxt_idx;
  logic [N-1:0]  mag, quot;
  logic [4:0]    trial;
  logic          qbit;
  logic [3:0]    rem_step;

  function automatic logic [7:0] ascii(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign xfer     = out_valid & out_ready;
  assign mag      = in_value[N-1] ? -in_value : in_value;
  assign top_idx  = dcount - CW'(1);
  assign nxt_idx  = dcount - CW'(2);

  // One restoring-division step: quotient bits shift into work from the right.
  assign trial    = {rem, work[N-1]};
  assign qbit     = (trial >= 5'd10);
  assign rem_step = qbit ? 4'(trial - 5'd10) : trial[3:0];
  assign quot     = {work[N-2:0], qbit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      rem       <= '0;
      bit_cnt   <= '0;
      dcount    <= '0;
      neg       <= 1'b0;
      err_idx   <= '0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      work      <= work_n;
      rem       <= rem_n;
      bit_cnt   <= bit_cnt_n;
      dcount    <= dcount_n;
      neg       <= neg_n;
      err_idx   <= err_idx_n;
      out_valid <= out_valid_n;
      out_char  <= out_char_n;
      out_last  <= out_last_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack[dcount] <= rem_step;
  end

  always_comb begin
    state_n     = state;
    work_n      = work;
    rem_n       = rem;
    bit_cnt_n   = bit_cnt;
    dcount_n    = dcount;
    neg_n       = neg;
    err_idx_n   = err_idx;
    out_valid_n = out_valid;
    out_char_n  = out_char;
    out_last_n  = out_last;
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_overflow) begin
            state_n     = ERR;
            err_idx_n   = 2'd0;
            out_valid_n = 1'b1;
            out_char_n  = 8'h4F;
            out_last_n  = 1'b0;
          end else begin
            state_n   = CONV;
            work_n    = mag;
            neg_n     = in_value[N-1];
            rem_n     = '0;
            bit_cnt_n = '0;
            dcount_n  = '0;
          end
        end
      end
      CONV: begin
        work_n    = quot;
        rem_n     = rem_step;
        bit_cnt_n = bit_cnt + BW'(1);
        if (bit_cnt == LAST_BIT) begin
          push      = 1'b1;
          rem_n     = '0;
          bit_cnt_n = '0;
          dcount_n  = dcount + CW'(1);
          if (quot == '0) begin
            out_valid_n = 1'b1;
            if (neg) begin
              state_n    = SIGN;
              out_char_n = 8'h2D;
              out_last_n = 1'b0;
            end else begin
              state_n    = EMIT;
              out_char_n = ascii(rem_step);
              out_last_n = (dcount == '0) && !TERM_NUL;
            end
          end
        end
      end
      SIGN: begin
        if (xfer) begin
          state_n    = EMIT;
          out_char_n = ascii(stack[top_idx]);
          out_last_n = (dcount == CW'(1)) && !TERM_NUL;
        end
      end
      EMIT: begin
        // dcount == 0 inside EMIT means the NUL terminator is being presented.
        if (xfer) begin
          if (dcount == '0) begin
            state_n = IDLE;
          end else if (dcount == CW'(1)) begin
            dcount_n = '0;
            if (TERM_NUL) begin
              out_char_n = 8'h00;
              out_last_n = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            dcount_n   = dcount - CW'(1);
            out_char_n = ascii(stack[nxt_idx]);
            out_last_n = (dcount == CW'(2)) && !TERM_NUL;
          end
        end
      end
      ERR: begin
        if (xfer) begin
          case (err_idx)
            2'd0: begin
              out_char_n = 8'h56;
              err_idx_n  = 2'd1;
            end
            2'd1: begin
              out_char_n = 8'h46;
              out_last_n = !TERM_NUL;
              err_idx_n  = 2'd2;
            end
            2'd2: begin
              if (TERM_NUL) begin
                out_char_n = 8'h00;
                out_last_n = 1'b1;
                err_idx_n  = 2'd3;
              end else begin
                state_n = IDLE;
              end
            end
            default: state_n = IDLE;
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE && state != IDLE) begin
      out_valid_n = 1'b0;
      out_char_n  = 8'h00;
      out_last_n  = 1'b0;
    end
  end

endmodule

// File: tb/tb_result_fmt.sv
// Self-checking bench for result_fmt: expected strings are queued at stimulus time and a
// negedge monitor pops and compares every transferred byte.
module tb_result_fmt;
  localparam int N = 16;
`ifdef RESULT_FMT_TERM_NUL_EN
  localparam bit TERM_NUL = 1'b1;
`else
  localparam bit TERM_NUL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_value;
  logic         in_overflow;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_char;
  logic         out_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] ch;
    logic       last;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  result_fmt #(.N(N), .DIGITS(5)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_value(in_value),
    .in_overflow(in_overflow),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_char(out_char),
    .out_last(out_last),
    .busy(busy)
  );

  // Inputs change only #1 after posedge, so the negedge sample equals what the next edge sees.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_byte got char=%h last=%b required no byte", out_char, out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_char !== mon_e.ch || out_last !== mon_e.last) begin
          errors++;
          $display("[TB] FAIL byte got char=%h last=%b required char=%h last=%b",
                   out_char, out_last, mon_e.ch, mon_e.last);
        end
      end
    end
  end

  task automatic push_string(input string s);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.ch   = s[i];
      e.last = (i == s.len() - 1) && !TERM_NUL;
      exp_q.push_back(e);
    end
    if (TERM_NUL) begin
      e.ch   = 8'h00;
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one accepted input; returns 1 time unit after the accept edge.
  task automatic drive_input(input int v, input bit ovf);
    push_string(ovf ? "OVF" : $sformatf("%0d", v));
    in_value    = N'(v);
    in_overflow = ovf;
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
    in_overflow = 1'b0;
  endtask

  // Cycle index of the first out_valid, counting the accept cycle as 0.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 400) begin
      step();
      lat++;
    end
  endtask

  task automatic drain(input bit bp, output bit timeout, output bit busy_drop, output bit unstable);
    int n = 0;
    bit stalled;
    logic [7:0] pch;
    logic plast;
    timeout = 0; busy_drop = 0; unstable = 0;
    while (exp_q.size() != 0) begin
      if (busy !== 1'b1) busy_drop = 1;
      if (n >= 400) begin
        timeout = 1;
        exp_q.delete();
        break;
      end
      if (bp) out_ready = (n % 3 == 0);
      stalled = out_valid && !out_ready;
      pch = out_char;
      plast = out_last;
      step();
      n++;
      if (stalled && (out_valid !== 1'b1 || out_char !== pch || out_last !== plast)) unstable = 1;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_value = '0; in_overflow = 1'b0; out_ready = 1'b1;
    repeat (2) step();
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b required 0", out_valid); end
    if (out_char !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_char got %h required 00", out_char); end
    if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last got %b required 0", out_last); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b required 0", busy); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_value(input int v, input int exp_lat);
    int lat;
    bit to, bd, us;
    drive_input(v, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat != exp_lat) begin errors++; $display("[TB] FAIL latency_%0d got %0d required %0d", v, lat, exp_lat); end
    drain(1'b0, to, bd, us);
    checks += 3;
    if (to) begin errors++; $display("[TB] FAIL drain_%0d got timeout required completion", v); end
    if (bd) begin errors++; $display("[TB] FAIL busy_%0d got low required high", v); end
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_%0d got in_ready=%b busy=%b required 1 0", v, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit to, bd, us;
    drive_input(-32768, 1'b0);
    drain(1'b0, to, bd, us);
    checks += 3;
    if (to) begin errors++; $display("[TB] FAIL b2b_first got timeout required completion"); end
    if (bd) begin errors++; $display("[TB] FAIL b2b_first_busy got low required high"); end
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready got %b required 1", in_ready); end
    drive_input(32767, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat != 81) begin errors++; $display("[TB] FAIL b2b_latency got %0d required 81", lat); end
    drain(1'b0, to, bd, us);
    checks += 2;
    if (to) begin errors++; $display("[TB] FAIL b2b_second got timeout required completion"); end
    if (bd) begin errors++; $display("[TB] FAIL b2b_second_busy got low required high"); end
  endtask

  task automatic test_overflow();
    int lat;
    bit to, bd, us;
    drive_input(1234, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat != 1) begin errors++; $display("[TB] FAIL ovf_latency got %0d required 1", lat); end
    drain(1'b0, to, bd, us);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL ovf_drain got timeout required completion"); end
  endtask

  task automatic test_backpressure();
    int lat;
    bit to, bd, us;
    drive_input(1234, 1'b0);
    wait_valid(lat);
    drain(1'b1, to, bd, us);
    checks += 2;
    if (to) begin errors++; $display("[TB] FAIL bp_drain got timeout required completion"); end
    if (us) begin errors++; $display("[TB] FAIL bp_stable got changed required stable while stalled"); end
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    int remaining = TERM_NUL ? 2 : 1;
    bit quiet = 1;
    out_ready = 1'b1;
    drive_input(-323, 1'b0);
    while (exp_q.size() > remaining && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (n >= 400) begin errors++; $display("[TB] FAIL midreset_wait got timeout required byte '2'"); end
    rst = 1'b1;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid got %b required 0", out_valid); end
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_idle got in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
    exp_q.delete();
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      if (out_valid !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin errors++; $display("[TB] FAIL midreset_quiet got out_valid=1 required 0"); end
    test_value(7, 17);
  endtask

  initial begin
    $display("[TB] result_fmt bench start (TERM_NUL=%0d)", TERM_NUL);
    test_reset();
    test_value(-323, 49);
    test_value(0, 17);
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_reset_midstream();
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_fmt.md
Name: result_fmt

Overview:
- Output side of the expression evaluator: turns a signed N-bit evaluation result plus its overflow flag back into ASCII text.
- Accepts one result per valid/ready handshake and emits the decimal string one byte per handshake, most-significant character first.
- Intended to feed a UART or trace printer downstream of the evaluator.
- Conversion is sequential: a restoring divide-by-10, one quotient bit per cycle, with digits buffered in a LIFO.

Parameters:
- N, 16: width of signed input value.
- DIGITS, 5: digit-stack depth. Must be >= ceil(N*log10(2)); 5 covers N=16.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input result available.
- in_ready  out  1  block can accept a result.
- in_value  in  N  signed two's-complement result.
- in_overflow  in  1  result invalid, print overflow marker instead.
- out_valid  out  1  out_char holds a valid byte.
- out_ready  in  1  sink accepts the byte.
- out_char  out  8  ASCII byte.
- out_last  out  1  marks the final byte of the string.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, out_char=8'h00, out_last=0, busy=0, digit count=0, neg flag=0. Reset mid-conversion or mid-emission abandons the string immediately; no partial bytes follow.
- Input accept: only in IDLE (in_ready=1 only there). An accept (in_valid & in_ready) captures the value, overflow flag, sign and magnitude.
- Magnitude: N-bit unsigned |in_value|. -2^(N-1) maps to magnitude 2^(N-1), which fits.
- States: IDLE, CONV, SIGN, EMIT, ERR.
- IDLE:
  - accept with in_overflow=1 -> ERR.
  - accept with in_overflow=0 -> CONV.
- CONV:
  - Restoring division of the working value by 10, MSB first, exactly N cycles per digit.
  - After the Nth cycle, push the remainder (0-9) onto the digit stack and replace the working value with the quotient.
  - If quotient != 0, start the next digit. If quotient == 0, go to SIGN when negative, else EMIT.
  - At least one digit is always produced, so value 0 yields "0".
  - Digit count never exceeds DIGITS for legal parameters.
- SIGN: present '-' (8'h2D) with out_last=0; on handshake -> EMIT.
- EMIT:
  - Present 8'h30 + top-of-stack; on handshake pop.
  - out_last=1 when exactly one digit remains; the handshake on that byte -> IDLE.
- ERR: emit 'O','V','F' (8'h4F, 8'h56, 8'h46); out_last=1 on 'F'; -> IDLE after its handshake.
- Output handshake: a byte transfers when out_valid & out_ready. While out_valid=1 and out_ready=0, out_char and out_last hold stable. out_valid never drops without a transfer, except on reset.
- Timing: out_valid is registered.
  - First byte is valid the cycle after CONV completes, so latency from accept = N*digits + 1 cycles.
  - With out_ready held high, one byte per cycle.
  - ERR outputs its first byte the cycle after accept.
- No back-to-back overlap: the next accept is possible in the cycle after the last-byte handshake (in_ready re-asserts on entering IDLE).

Optional Feature:
- Macro: RESULT_FMT_TERM_NUL_EN.
- Defined: after the final character, one extra byte 8'h00 is emitted. out_last moves to the NUL byte; the preceding character has out_last=0. This applies to both numeric and OVF strings, producing C-style terminated strings compatible with NUL-padded expression buffers.
- Undefined: no terminator; out_last is on the final character.

Test Plan:
- in_value=-323 (the evaluator's result for "2 * 3 + (10 + 4 + 3) * -20 + (6 + 5)"), out_ready=1:
  - Bytes '-','3','2','3' with out_last on the final '3'.
  - First out_valid 49 cycles after accept (3 digits x 16 + 1).
- in_value=0 -> single byte '0' with out_last=1, 17 cycles after accept.
- in_value=-32768 then 32767, back to back:
  - First input produces "-32768".
  - Second input is accepted the cycle after the first string's last-byte handshake and produces "32767".
  - busy stays high throughout each string.
- in_overflow=1 with any value -> "OVF", out_last on 'F'.
  - With RESULT_FMT_TERM_NUL_EN: "OVF" followed by 8'h00, out_last on the 8'h00.
- Backpressure on in_value=1234: out_ready toggles 1,0,0,1,...
  - Each byte stays stable while stalled.
  - Sequence is exactly "1234", with no duplicated or dropped bytes.
- Reset mid-stream: assert rst after '2' of "-323" is transferred.
  - out_valid=0 and in_ready=1 immediately, with no remaining bytes.
  - A new input of 7 then yields only "7".
